// File: rtl/mem_stage_sized.sv
// MEM pipeline stage: word-organised data RAM behind a request/response handshake,
// with configurable access latency, sub-word loads/stores and address fault detection.
module mem_stage_sized #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            size,
  input  logic                  load_unsigned,
  input  logic [ADDR_WIDTH-1:0] ALU_out,
  input  logic [31:0]           RegB,
  output logic                  resp_valid,
  output logic [31:0]           Memory_Read_Data,
  output logic                  fault,
  output logic [1:0]            fault_code,
  output logic                  stall
);

  localparam int IDXW = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);
  localparam logic [1:0] BUSY_INIT = 2'(LATENCY > 1 ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  logic [IDXW-1:0] reqIdx_q;
  logic [1:0]      reqLane_q;
  logic [1:0]      reqSize_q;
  logic [31:0]     reqData_q;
  logic            reqRead_q, reqWrite_q, reqUns_q;

  logic        respValid_q, respFault_q;
  logic [31:0] respData_q;
  logic [1:0]  respCode_q;

  logic        accept, finish, inAccess, memWe;
  logic [1:0]  inCode, curCode, curLane, curSize;
  logic        curRead, curWrite, curUns;
  logic [IDXW-1:0] curIdx;
  logic [31:0] curData, rdWord, shifted, loadExt, wrData, respData_d;
  logic [3:0]  byteEn;

  logic [31:0] mem [DEPTH_WORDS];

  // Fault classification of the incoming request; no-ops never fault.
  always_comb begin
    inAccess = MemRead | MemWrite;
    inCode   = 2'b00;
    if (inAccess) begin
      if ((MemRead & MemWrite) || size == 2'b11)
        inCode = 2'b11;
      else if ({1'b0, ALU_out} >= LIMIT)
        inCode = 2'b10;
      else if ((size == 2'b01 && ALU_out[0]) || (size == 2'b10 && ALU_out[1:0] != 2'b00))
        inCode = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (req_valid) begin
          if (inCode != 2'b00 || !inAccess || LATENCY == 1) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            cnt_d   = BUSY_INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == 2'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q != BUSY);
    stall     = (req_valid & ~req_ready) | (state_q == BUSY);
    accept    = req_valid & req_ready;
    finish    = (state_d == DONE);
  end

  // The finishing edge is either the accept edge itself or the end of BUSY,
  // so the access uses live inputs or the captured request accordingly.
  always_comb begin
    curIdx   = accept ? ALU_out[IDXW+1:2] : reqIdx_q;
    curLane  = accept ? ALU_out[1:0]      : reqLane_q;
    curSize  = accept ? size              : reqSize_q;
    curData  = accept ? RegB              : reqData_q;
    curRead  = accept ? MemRead           : reqRead_q;
    curWrite = accept ? MemWrite          : reqWrite_q;
    curUns   = accept ? load_unsigned     : reqUns_q;
    curCode  = accept ? inCode            : 2'b00;

    case (curSize)
      2'b00:   begin byteEn = 4'b0001 << curLane;              wrData = {4{curData[7:0]}};  end
      2'b01:   begin byteEn = 4'b0011 << {curLane[1], 1'b0};   wrData = {2{curData[15:0]}}; end
      default: begin byteEn = 4'b1111;                         wrData = curData;            end
    endcase

    rdWord  = mem[curIdx];
    shifted = rdWord >> {curLane, 3'b000};
    case (curSize)
      2'b00:   loadExt = curUns ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   loadExt = curUns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: loadExt = shifted;
    endcase

    respData_d = (curCode == 2'b00 && curRead) ? loadExt : 32'd0;
    memWe      = reset & finish & curWrite & (curCode == 2'b00);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reqIdx_q    <= '0;
      reqLane_q   <= 2'd0;
      reqSize_q   <= 2'd0;
      reqData_q   <= 32'd0;
      reqRead_q   <= 1'b0;
      reqWrite_q  <= 1'b0;
      reqUns_q    <= 1'b0;
      respValid_q <= 1'b0;
      respFault_q <= 1'b0;
      respCode_q  <= 2'b00;
      respData_q  <= 32'd0;
    end else begin
      if (accept) begin
        reqIdx_q   <= ALU_out[IDXW+1:2];
        reqLane_q  <= ALU_out[1:0];
        reqSize_q  <= size;
        reqData_q  <= RegB;
        reqRead_q  <= MemRead;
        reqWrite_q <= MemWrite;
        reqUns_q   <= load_unsigned;
      end
      respValid_q <= finish;
      if (finish) begin
        respFault_q <= (curCode != 2'b00);
        respCode_q  <= curCode;
        respData_q  <= respData_d;
      end
    end
  end

  // RAM has no reset so its contents survive a pipeline reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (memWe && byteEn[i]) mem[curIdx][8*i +: 8] <= wrData[8*i +: 8];
    end
  end

  assign resp_valid       = respValid_q;
  assign Memory_Read_Data = respData_q;
  assign fault            = respFault_q;
  assign fault_code       = respCode_q;

endmodule

// File: tb/tb_mem_stage_sized.sv
// Testbench for mem_stage_sized: one instance at LATENCY=1 and one at LATENCY=3,
// expected responses queued at accept and checked when resp_valid strobes.
module tb_mem_stage_sized;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstA, rstB, reqValidA, reqValidB;
  logic        memRead, memWrite, loadUns;
  logic [1:0]  size;
  logic [31:0] addr, regB;

  logic        readyA, respValidA, faultA, stallA;
  logic [31:0] rdataA;
  logic [1:0]  codeA;
  logic        readyB, respValidB, faultB, stallB;
  logic [31:0] rdataB;
  logic [1:0]  codeB;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        flt;
    logic [1:0]  code;
  } exp_t;

  exp_t qA[$];
  exp_t qB[$];

  mem_stage_sized #(.ADDR_WIDTH(32), .DEPTH_WORDS(256), .LATENCY(1)) dutA (
    .clk(clk), .reset(rstA), .req_valid(reqValidA), .req_ready(readyA),
    .MemRead(memRead), .MemWrite(memWrite), .size(size), .load_unsigned(loadUns),
    .ALU_out(addr), .RegB(regB), .resp_valid(respValidA), .Memory_Read_Data(rdataA),
    .fault(faultA), .fault_code(codeA), .stall(stallA)
  );

  mem_stage_sized #(.ADDR_WIDTH(32), .DEPTH_WORDS(256), .LATENCY(3)) dutB (
    .clk(clk), .reset(rstB), .req_valid(reqValidB), .req_ready(readyB),
    .MemRead(memRead), .MemWrite(memWrite), .size(size), .load_unsigned(loadUns),
    .ALU_out(addr), .RegB(regB), .resp_valid(respValidB), .Memory_Read_Data(rdataB),
    .fault(faultB), .fault_code(codeB), .stall(stallB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic checkResp(input string tag, input exp_t e, input logic [31:0] data,
                           input logic flt, input logic [1:0] code);
    checkOutput({tag, "_cycle"}, 32'(cyc), 32'(e.cyc));
    checkOutput({tag, "_data"}, data, e.data);
    checkOutput({tag, "_fault"}, 32'(flt), 32'(e.flt));
    checkOutput({tag, "_code"}, 32'(code), 32'(e.code));
  endtask

  // Scoreboard consumers: every resp_valid strobe must match the oldest expectation.
  always @(negedge clk) begin : monA
    exp_t e;
    if (respValidA === 1'b1) begin
      total++;
      assert (qA.size() > 0) else begin
        bad++;
        $error("[TB] FAIL spuriousA observed=resp_valid expected=no response");
      end
      if (qA.size() > 0) begin
        e = qA.pop_front();
        checkResp("respA", e, rdataA, faultA, codeA);
      end
    end
  end

  always @(negedge clk) begin : monB
    exp_t e;
    if (respValidB === 1'b1) begin
      total++;
      assert (qB.size() > 0) else begin
        bad++;
        $error("[TB] FAIL spuriousB observed=resp_valid expected=no response");
      end
      if (qB.size() > 0) begin
        e = qB.pop_front();
        checkResp("respB", e, rdataB, faultB, codeB);
      end
    end
  end

  // Drives one request, waits (bounded) for acceptance, and queues the expected response.
  task automatic applyStimulus(input bit onB, input bit rd, input bit wr, input logic [1:0] sz,
                               input bit uns, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] expData, input bit expFlt,
                               input logic [1:0] expCode, output int waits);
    exp_t e;
    int   lat;
    memRead  = rd;
    memWrite = wr;
    size     = sz;
    loadUns  = uns;
    addr     = a;
    regB     = d;
    if (onB) reqValidB = 1'b1;
    else     reqValidA = 1'b1;
    lat   = (expFlt || (!rd && !wr)) ? 1 : (onB ? 3 : 1);
    waits = 0;
    @(negedge clk);
    while ((onB ? readyB : readyA) !== 1'b1 && waits < 20) begin
      checkOutput(onB ? "stallWhileHeldB" : "stallWhileHeldA", 32'(onB ? stallB : stallA), 32'd1);
      waits++;
      @(negedge clk);
    end
    if ((onB ? readyB : readyA) !== 1'b1) begin
      checkOutput("acceptTimeout", 32'(onB ? readyB : readyA), 32'd1);
    end else begin
      e.cyc  = cyc + lat;
      e.data = expData;
      e.flt  = expFlt;
      e.code = expCode;
      if (onB) qB.push_back(e);
      else     qA.push_back(e);
    end
    @(posedge clk);
    #1;
    reqValidA = 1'b0;
    reqValidB = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   w;
    exp_t dropped;
    rstA = 1'b1; rstB = 1'b1; reqValidA = 1'b0; reqValidB = 1'b0;
    memRead = 1'b0; memWrite = 1'b0; size = 2'b00; loadUns = 1'b0; addr = '0; regB = '0;
    #2;
    rstA = 1'b0; rstB = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstRespValidA", 32'(respValidA), 32'd0);
    checkOutput("rstDataA", rdataA, 32'd0);
    checkOutput("rstFaultA", 32'(faultA), 32'd0);
    checkOutput("rstCodeA", 32'(codeA), 32'd0);
    checkOutput("rstRespValidB", 32'(respValidB), 32'd0);
    rstA = 1'b1; rstB = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("readyA", 32'(readyA), 32'd1);
    checkOutput("readyB", 32'(readyB), 32'd1);
    checkOutput("idleStallA", 32'(stallA), 32'd0);

    // LATENCY=1: word store then back-to-back load in the DONE cycle
    applyStimulus(0, 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2'b00, w);
    applyStimulus(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2'b00, w);
    checkOutput("b2bWaitsA", 32'(w), 32'd0);
    applyStimulus(0, 0, 1, 2'b00, 0, 32'h13, 32'hAAAAAA7F, 32'h0, 0, 2'b00, w);
    applyStimulus(0, 1, 0, 2'b00, 0, 32'h13, 32'h0, 32'h0000007F, 0, 2'b00, w);
    applyStimulus(0, 0, 1, 2'b00, 0, 32'h12, 32'hAAAAAA80, 32'h0, 0, 2'b00, w);
    applyStimulus(0, 1, 0, 2'b00, 0, 32'h12, 32'h0, 32'hFFFFFF80, 0, 2'b00, w);
    applyStimulus(0, 1, 0, 2'b00, 1, 32'h12, 32'h0, 32'h00000080, 0, 2'b00, w);
    applyStimulus(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h7F80BEEF, 0, 2'b00, w);
    applyStimulus(0, 1, 0, 2'b00, 0, 32'h11, 32'h0, 32'hFFFFFFBE, 0, 2'b00, w);
    applyStimulus(0, 1, 0, 2'b01, 1, 32'h10, 32'h0, 32'h0000BEEF, 0, 2'b00, w);

    // Halfword store into the upper lanes of a zeroed word
    applyStimulus(0, 0, 1, 2'b10, 0, 32'h20, 32'h00000000, 32'h0, 0, 2'b00, w);
    applyStimulus(0, 0, 1, 2'b01, 0, 32'h22, 32'h55558001, 32'h0, 0, 2'b00, w);
    applyStimulus(0, 1, 0, 2'b01, 0, 32'h22, 32'h0, 32'hFFFF8001, 0, 2'b00, w);
    applyStimulus(0, 1, 0, 2'b01, 1, 32'h22, 32'h0, 32'h00008001, 0, 2'b00, w);
    applyStimulus(0, 1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h80010000, 0, 2'b00, w);

    // Faults, priorities and range boundary
    applyStimulus(0, 1, 0, 2'b10, 0, 32'h11, 32'h0, 32'h0, 1, 2'b01, w);
    applyStimulus(0, 1, 0, 2'b01, 0, 32'h23, 32'h0, 32'h0, 1, 2'b01, w);
    applyStimulus(0, 0, 1, 2'b10, 0, 32'h0, 32'hCAFEF00D, 32'h0, 0, 2'b00, w);
    applyStimulus(0, 0, 1, 2'b10, 0, 32'h400, 32'h12345678, 32'h0, 1, 2'b10, w);
    applyStimulus(0, 1, 0, 2'b10, 0, 32'h0, 32'h0, 32'hCAFEF00D, 0, 2'b00, w);
    applyStimulus(0, 1, 0, 2'b10, 0, 32'h402, 32'h0, 32'h0, 1, 2'b10, w);
    applyStimulus(0, 1, 1, 2'b10, 0, 32'h401, 32'h87654321, 32'h0, 1, 2'b11, w);
    applyStimulus(0, 1, 0, 2'b11, 0, 32'h0, 32'h0, 32'h0, 1, 2'b11, w);
    applyStimulus(0, 1, 0, 2'b10, 0, 32'h0, 32'h0, 32'hCAFEF00D, 0, 2'b00, w);
    applyStimulus(0, 0, 1, 2'b10, 0, 32'h3FC, 32'h0BADC0DE, 32'h0, 0, 2'b00, w);
    applyStimulus(0, 1, 0, 2'b10, 0, 32'h3FC, 32'h0, 32'h0BADC0DE, 0, 2'b00, w);
    applyStimulus(0, 0, 0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0, 2'b00, w);
    repeat (2) @(posedge clk);
    #1;

    // LATENCY=3: second request held off until DONE
    applyStimulus(1, 0, 1, 2'b10, 0, 32'h40, 32'h11223344, 32'h0, 0, 2'b00, w);
    checkOutput("busyReadyB", 32'(readyB), 32'd0);
    applyStimulus(1, 1, 0, 2'b10, 0, 32'h40, 32'h0, 32'h11223344, 0, 2'b00, w);
    checkOutput("holdOffWaitsB", 32'(w), 32'd2);
    repeat (4) @(posedge clk);
    #1;
    applyStimulus(1, 1, 0, 2'b10, 0, 32'h41, 32'h0, 32'h0, 1, 2'b01, w);
    repeat (2) @(posedge clk);
    #1;

    // Reset while a store is in flight: aborted, no write, no response
    applyStimulus(1, 0, 1, 2'b10, 0, 32'h40, 32'h99999999, 32'h0, 0, 2'b00, w);
    rstB = 1'b0;
    dropped = qB.pop_back();
    #1;
    checkOutput("abortRespValidB", 32'(respValidB), 32'd0);
    checkOutput("abortFaultB", 32'(faultB), 32'd0);
    checkOutput("abortCodeB", 32'(codeB), 32'd0);
    checkOutput("abortDataB", rdataB, 32'd0);
    checkOutput("abortStallB", 32'(stallB), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rstB = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("postAbortReadyB", 32'(readyB), 32'd1);
    applyStimulus(1, 1, 0, 2'b10, 0, 32'h40, 32'h0, 32'h11223344, 0, 2'b00, w);

    repeat (6) @(posedge clk);
    #1;
    checkOutput("pendingA", 32'(qA.size()), 32'd0);
    checkOutput("pendingB", 32'(qB.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_sized.md
Name: mem_stage_sized

Overview:
- Next-generation MEM stage for the pipeline.
- Wraps a word-organised data RAM behind a request/response handshake.
- Supports byte, halfword and word loads and stores, with sign or zero extension.
- Adds a configurable access latency, plus fault detection for misaligned or out-of-range addresses.
- Sits between EX/MEM and MEM/WB; the pipeline stalls while `stall` is high.

Parameters:
- ADDR_WIDTH, 32: width of the byte address ALU_out.
- DEPTH_WORDS, 256: number of 32-bit words in the RAM. Must be a power of two, at least 4.
- LATENCY, 1: cycles from request accept to resp_valid for a legal access. Range 1..4.

Ports:
- clk, in, 1: clock, rising edge.
- reset, in, 1: asynchronous, active-low reset.
- req_valid, in, 1: request present.
- req_ready, out, 1: request can be accepted this cycle.
- MemRead, in, 1: load request.
- MemWrite, in, 1: store request.
- size, in, 2: access size. 00 = byte, 01 = half, 10 = word, 11 = illegal.
- load_unsigned, in, 1: 1 = zero-extend the load result, 0 = sign-extend.
- ALU_out, in, ADDR_WIDTH: byte address, little-endian.
- RegB, in, 32: store data. Low bits are used for byte and half stores.
- resp_valid, out, 1: one-cycle response strobe.
- Memory_Read_Data, out, 32: extended load result. 0 for stores, no-ops and faults.
- fault, out, 1: valid only with resp_valid. Access was not performed.
- fault_code, out, 2: 01 = misaligned, 10 = out of range, 11 = illegal (MemRead & MemWrite, or size = 11).
- stall, out, 1: request held or in flight. Equals (req_valid & ~req_ready) | (state == BUSY).

Behaviour:
- Reset (reset = 0, async):
  - state = IDLE, counter = 0.
  - resp_valid, fault, fault_code, Memory_Read_Data all 0.
  - req_ready = 1 once reset deasserts.
  - RAM contents are not affected by reset.
- FSM states:
  - IDLE: req_ready = 1.
    - Accept when req_valid.
    - Faulting or no-op request (MemRead = MemWrite = 0): go to DONE.
    - Legal access: if LATENCY = 1 go to DONE, else go to BUSY with counter = LATENCY-2.
  - BUSY: req_ready = 0. Decrement the counter; go to DONE when the counter reaches 0.
  - DONE: resp_valid = 1 for this cycle; req_ready = 1.
    - A new request accepted here follows the same rules as in IDLE (back-to-back operation).
    - Otherwise go to IDLE.
- Latency: a request accepted in cycle T gives resp_valid in cycle T+LATENCY for a legal access. Faults and no-ops respond at T+1.
- The request (addr, data, size, flags) is captured into registers at accept. Inputs may change afterwards.
- Fault priority: illegal (11) > out of range (10) > misaligned (01).
  - Out of range: ALU_out >= 4*DEPTH_WORDS.
  - Misaligned: a half access with addr[0] = 1, or a word access with addr[1:0] != 0.
  - A faulting store never modifies the RAM.
- Store commit:
  - The RAM word index is addr[log2(DEPTH_WORDS)+1:2].
  - Byte enables are derived from size and addr[1:0]:
    - byte: lane addr[1:0];
    - half: lanes {addr[1],0} and {addr[1],1};
    - word: all lanes.
  - The write happens on the clock edge that enters DONE, so a load accepted in the DONE cycle sees the new data.
- Load:
  - The word is read at the edge entering DONE.
  - The selected lane(s) are shifted down and extended per load_unsigned.
  - The registered result is presented in DONE.
- Outputs are registered.
  - Memory_Read_Data and fault are held until the next response and are meaningful only while resp_valid = 1.
- Reset during BUSY aborts the access with no RAM write and no response.

Test Plan:
- LATENCY=1, store word 0xDEADBEEF to 0x10, then load word from 0x10 back-to-back in the DONE cycle -> resp_valid one cycle after each accept; load returns 0xDEADBEEF.
- After the above, store byte 0x7F to 0x13, then lb 0x13 -> 0x0000007F; store byte 0x80 to 0x12, lb 0x12 -> 0xFFFFFF80, lbu 0x12 -> 0x00000080; lw 0x10 -> 0x7F80BEEF.
- Store half 0x8001 to 0x22, then lh 0x22 -> 0xFFFF8001, lhu 0x22 -> 0x00008001; lw 0x20 -> upper half 0x8001.
- lw 0x11 -> fault = 1, fault_code = 01 at T+1; sw to 4*DEPTH_WORDS -> fault_code = 10 and RAM unchanged (check by readback); MemRead = MemWrite = 1 -> fault_code = 11.
- LATENCY=3, request held: stall = 1 and req_ready = 0 for two cycles; resp_valid exactly at T+3; a second req_valid is held off until the DONE cycle.
- Assert reset (0) while BUSY with a store pending -> all outputs 0 immediately; after release, readback shows the old value; no spurious resp_valid.
